// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product stream in, saturated sum out, both valid/ready
interface product_accumulator_if #(
    parameter int PW = 16,
    parameter int AW = 24
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_ovf;
    logic [7:0]    count;

    modport master (
        output in_valid, in_prod, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, count
    );

    modport slave (
        input  in_valid, in_prod, flush, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, count
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums N unsigned products into a saturating accumulator, result held until taken
module product_accumulator #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int N  = 4
) (
    input  logic clk,
    input  logic rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        state, state_n;
    logic [AW-1:0] acc, acc_n, acc_nx, sum_q, sum_n;
    logic [AW:0]   raw;
    logic [7:0]    cnt, cnt_n;
    logic          ovf, ovf_n, ovf_nx, ovf_q, oovf_n, accept, done;

    assign bus.in_ready  = state != HOLD;
    assign bus.out_valid = state == HOLD;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.count     = cnt;

    assign accept = bus.in_valid && bus.in_ready;
    assign raw    = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};
    assign acc_nx = !accept ? acc : raw[AW] ? '1 : raw[AW-1:0];
    assign ovf_nx = ovf | (accept & raw[AW]);
    // flush with nothing accepted so far and nothing arriving is a no-op
    assign done   = state != HOLD &&
                    ((accept && cnt + 8'd1 == 8'(N)) || (bus.flush && (cnt != 8'd0 || accept)));

    // next state: close a result, fold in a product, or wait for the result to be taken
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        sum_n   = sum_q;
        oovf_n  = ovf_q;
        if (state == HOLD) begin
            state_n = bus.out_ready ? IDLE : HOLD;
        end else if (done) begin
            state_n = HOLD;
            sum_n   = acc_nx;
            oovf_n  = ovf_nx;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else if (accept) begin
            state_n = ACCUM;
            acc_n   = acc_nx;
            cnt_n   = cnt + 8'd1;
            ovf_n   = ovf_nx;
        end
    end

    // state and datapath registers; reset drops any partial or held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
            sum_q <= sum_n;
            ovf_q <= oovf_n;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: table vectors plus scoreboard across three configurations
module tb_product_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  sel = 0;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [15:0] in_prod = 0;

    product_accumulator_if #(.PW(16), .AW(24)) a();
    product_accumulator_if #(.PW(16), .AW(17)) b();
    product_accumulator_if #(.PW(16), .AW(24)) c();

    product_accumulator #(.PW(16), .AW(24), .N(4)) u_a (.clk(clk), .rst(rst), .bus(a.slave));
    product_accumulator #(.PW(16), .AW(17), .N(4)) u_b (.clk(clk), .rst(rst), .bus(b.slave));
    product_accumulator #(.PW(16), .AW(24), .N(1)) u_c (.clk(clk), .rst(rst), .bus(c.slave));

    assign a.in_valid = in_valid && sel == 0;
    assign b.in_valid = in_valid && sel == 1;
    assign c.in_valid = in_valid && sel == 2;
    assign a.flush = flush && sel == 0;
    assign b.flush = flush && sel == 1;
    assign c.flush = flush && sel == 2;
    assign a.in_prod = in_prod;
    assign b.in_prod = in_prod;
    assign c.in_prod = in_prod;
    assign a.out_ready = out_ready;
    assign b.out_ready = out_ready;
    assign c.out_ready = out_ready;

    always #5 clk = ~clk;

    logic        rdy_m, val_m, ovf_m;
    logic [23:0] sum_m;
    logic [7:0]  cnt_m;

    // view of the configuration under test
    always_comb begin
        rdy_m = sel == 1 ? b.in_ready : sel == 2 ? c.in_ready : a.in_ready;
        val_m = sel == 1 ? b.out_valid : sel == 2 ? c.out_valid : a.out_valid;
        ovf_m = sel == 1 ? b.out_ovf : sel == 2 ? c.out_ovf : a.out_ovf;
        sum_m = sel == 1 ? 24'(b.out_sum) : sel == 2 ? c.out_sum : a.out_sum;
        cnt_m = sel == 1 ? b.count : sel == 2 ? c.count : a.count;
    end

    typedef struct {
        logic [1:0]  sel;
        logic        v;
        logic [15:0] p;
        logic        f;
        logic        r;
        logic        ev;
        logic [7:0]  ec;
    } vec_t;

    typedef struct {
        longint sum;
        bit     ovf;
    } res_t;

    vec_t   tbl[$];
    res_t   q[$];
    int     n_vec = 0, n_err = 0;
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 0, m_hold = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int s, v, p, f, r, ev, ec);
        vec_t t;
        t.sel = 2'(s); t.v = 1'(v); t.p = 16'(p); t.f = 1'(f); t.r = 1'(r);
        t.ev = 1'(ev); t.ec = 8'(ec);
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        q.delete();
    endtask

    // one clock: drive, check before the edge, advance the reference model
    task automatic cycle(input logic v, input logic [15:0] p, input logic f, input logic r);
        longint s, mx;
        int     nn;
        res_t   e;
        in_valid = v; in_prod = p; flush = f; out_ready = r;
        @(negedge clk);
        chk("in_ready", rdy_m, !m_hold);
        chk("out_valid", val_m, m_hold);
        chk("count", cnt_m, m_cnt);
        if (val_m) begin
            if (q.size() == 0) chk("spurious_result", val_m, 0);
            else begin
                chk("out_sum", sum_m, q[0].sum);
                chk("out_ovf", ovf_m, q[0].ovf);
                if (r) void'(q.pop_front());
            end
        end
        nn = sel == 2 ? 1 : 4;
        mx = sel == 1 ? 64'h1FFFF : 64'hFFFFFF;
        if (m_hold) begin
            if (r) m_hold = 0;
        end else begin
            if (v) begin
                s = m_acc + longint'(p);
                if (s > mx) m_ovf = 1;
                m_acc = s > mx ? mx : s;
                m_cnt++;
            end
            if (m_cnt == nn || (f && m_cnt > 0)) begin
                e.sum = m_acc; e.ovf = m_ovf;
                q.push_back(e);
                m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic sum 100..400
        add(0,1,100,0,1,0,0); add(0,1,200,0,1,0,1); add(0,1,300,0,1,0,2); add(0,1,400,0,1,0,3);
        add(0,0,0,0,1,1,0);   add(0,0,0,0,1,0,0);
        // flush after 7,9; flush with accept of 5 after 7; idle flush ignored
        add(0,1,7,0,1,0,0);   add(0,1,9,0,1,0,1);   add(0,0,0,1,1,0,2);   add(0,0,0,0,1,1,0);
        add(0,1,7,0,1,0,0);   add(0,1,5,1,1,0,1);   add(0,0,0,0,1,1,0);
        add(0,0,0,1,1,0,0);   add(0,0,0,0,1,0,0);
        // backpressure: 10..40 then five stalled cycles offering 55
        add(0,1,10,0,0,0,0);  add(0,1,20,0,0,0,1);  add(0,1,30,0,0,0,2);  add(0,1,40,0,0,0,3);
        for (int i = 0; i < 5; i++) add(0,1,55,0,0,1,0);
        add(0,1,55,0,1,1,0);  add(0,1,55,0,1,0,0);  add(0,0,0,1,1,0,1);   add(0,0,0,0,1,1,0);
        add(0,0,0,0,1,0,0);
        // saturation on AW=17, then ovf must not carry into the next result
        for (int i = 0; i < 4; i++) add(1,1,16'hFFFF,0,1,0,i);
        add(1,0,0,0,1,1,0);
        for (int i = 0; i < 4; i++) add(1,1,1,0,1,0,i);
        add(1,0,0,0,1,1,0);   add(1,0,0,0,1,0,0);

        #12;
        chk("rst_in_ready", a.in_ready, 1);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_count", a.count, 0);
        chk("rst_out_sum", a.out_sum, 0);
        chk("rst_out_ovf", a.out_ovf, 0);
        @(posedge clk);
        #1 rst = 0;

        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            in_valid = tbl[i].v; in_prod = tbl[i].p; flush = tbl[i].f; out_ready = tbl[i].r;
            #2;
            chk($sformatf("tbl%0d_valid", i), val_m, tbl[i].ev);
            chk($sformatf("tbl%0d_count", i), cnt_m, tbl[i].ec);
            cycle(tbl[i].v, tbl[i].p, tbl[i].f, tbl[i].r);
        end

        // asynchronous reset between edges after two accepts
        sel = 0;
        cycle(1, 50, 0, 1);
        cycle(1, 60, 0, 1);
        in_valid = 0;
        #2 rst = 1;
        #1;
        chk("arst_in_ready", a.in_ready, 1);
        chk("arst_out_valid", a.out_valid, 0);
        chk("arst_count", a.count, 0);
        chk("arst_out_sum", a.out_sum, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0, 1);
        if (q.size() == 1) chk("arst_sum10", q[0].sum, 10);
        else chk("arst_queue", q.size(), 1);
        cycle(0, 0, 0, 1);

        // N=1 random handshake stress
        sel = 2;
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 4 && q.size() > 0; i++) cycle(0, 0, 0, 1);
        chk("pending_results", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 shift-and-add multiplier's registered 16-bit product.
- Accepts a stream of unsigned products over a valid/ready handshake and sums N of them into a wider accumulator (dot-product / MAC tail).
- Presents the sum, with a sticky overflow flag, on a valid/ready output port.

Parameters:
- PW, 16, product (input) width in bits; equals m+n of the upstream multiplier.
- AW, 24, accumulator/output width in bits; must be >= PW.
- N, 4, products per result; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_prod holds a valid product.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  PW  unsigned product from the multiplier.
- flush  input  1  close the current partial sum early; single-cycle pulse.
- out_valid  output  1  out_sum/out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  AW  accumulated (saturated) sum.
- out_ovf  output  1  saturation occurred during this result.
- count  output  8  products accepted into the current partial sum.

Behaviour:
- Reset:
  - Async, active-high.
  - State=IDLE; accumulator=0; count=0; out_valid=0; out_sum=0; out_ovf=0; in_ready=1.
  - Reset asserted mid-operation discards any partial sum or held result. No output is produced from that data.
- Accept event: in_valid && in_ready at a rising edge.
  - in_prod is zero-extended to AW bits and added.
  - If the true sum exceeds 2^AW-1, the accumulator saturates at 2^AW-1 and a sticky ovf bit is set for the current result.
- States:
  - IDLE: count=0, in_ready=1, out_valid=0.
  - ACCUM: 0<count<N, in_ready=1, out_valid=0.
  - HOLD: result presented, out_valid=1, in_ready=0.
- IDLE/ACCUM, accept without completion: accumulator updates, count increments. Next state is ACCUM.
- Completion: the accept that makes count reach N.
  - Next edge: out_sum = final saturated sum, out_ovf = final ovf, out_valid=1, state=HOLD.
  - Accumulator, count and ovf clear on the same edge.
  - Latency: out_valid rises exactly 1 cycle after the Nth accepted product.
- flush in IDLE/ACCUM:
  - If count>0, or an accept occurs in the same cycle, the result is closed as if completion occurred.
  - A product accepted in that same cycle is included in the sum.
  - flush with count=0 and no accept is ignored.
  - flush in HOLD is ignored.
- HOLD:
  - out_sum, out_ovf and out_valid stay stable until out_valid && out_ready.
  - On that edge: out_valid=0, state=IDLE, in_ready=1 from the next cycle.
  - No bubble-free overlap: at least one cycle with in_ready=1 precedes the next accept.
- in_ready is a registered or state-decoded output. It never depends combinationally on in_valid or out_ready.
- out_sum retains its last value after the handshake; it is only meaningful while out_valid=1.
- N=1: every accepted product produces a result. count never shows a value other than 0 in IDLE.
- No arithmetic wrap-around anywhere: saturation is the only overflow behaviour.

Test Plan:
- Basic sum, N=4, AW=24.
  - Stimulus: products 100, 200, 300, 400 back-to-back, out_ready=1.
  - Required: out_valid high 1 cycle after the 4th accept; out_sum=1000; out_ovf=0; count back to 0.
- Saturation, AW=17, N=4.
  - Stimulus: 4 products of 0xFFFF.
  - Required: out_sum=0x1FFFF, out_ovf=1.
  - Next result 1, 1, 1, 1 gives out_sum=4, out_ovf=0 (ovf is not sticky across results).
- Backpressure.
  - Stimulus: complete a result of 10, 20, 30, 40; hold out_ready=0 for 5 cycles while in_valid=1.
  - Required: in_ready=0, out_sum=100 stable, no product lost; the held input is accepted after the handshake.
- Flush.
  - Stimulus: products 7, 9, then flush alone.
  - Required: out_sum=16, count=0 afterwards.
  - Flush in the same cycle as accepting 5 after 7 gives out_sum=12.
  - Flush in IDLE with no accept gives no out_valid.
- Reset mid-operation.
  - Stimulus: after 2 accepts (50, 60), assert rst asynchronously between edges.
  - Required: outputs immediately 0, in_ready=1; after release, products 1, 2, 3, 4 give out_sum=10.
- N=1, random stress.
  - Stimulus: 1000 random in_valid/out_ready patterns.
  - Required: scoreboard matches every product in order; no result is dropped or duplicated.
